// File: rtl/multiword_adder_pkg.sv
// Shared constants, FSM encoding and carry-lookahead helper functions for the
// multi-word sequential adder and its 16-bit CLA slice.
package multiword_adder_pkg;

  localparam int SLICE_W  = 16;
  localparam int SLICE_LG = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int idx_w(input int words);
    return $clog2(words);
  endfunction

  // Lookahead carries into bits 1..3 of a 4-bit group, returned as {c3, c2, c1}.
  function automatic logic [2:0] cla3(input logic [2:0] g, input logic [2:0] p, input logic c);
    logic c1;
    logic c2;
    logic c3;
    c1 = g[0] | (p[0] & c);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    return {c3, c2, c1};
  endfunction

  function automatic logic gen4(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/multiword_adder_if.sv
// Request/result bundle between the operand source and the multi-word adder.
interface multiword_adder_if #(parameter int WORDS = 4);
  import multiword_adder_pkg::*;

  localparam int N = SLICE_W * WORDS;

  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;

  modport master (output start, sub, a, b, cin,
                  input  busy, done, sum, cout, overflow);
  modport slave  (input  start, sub, a, b, cin,
                  output busy, done, sum, cout, overflow);
endinterface

// File: rtl/multiword_adder_cla.sv
// 16-bit two-level carry-lookahead adder: 4-bit groups with group generate/propagate.
module sixteenbitscarrylookaheadadder
  import multiword_adder_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [15:0] c_s;
  logic [3:0]  gg_s;
  logic [3:0]  gp_s;
  logic [2:0]  gc_s;
  logic [3:0]  gcin_s;

  assign g_s    = a_i & b_i;
  assign p_s    = a_i ^ b_i;
  assign gc_s   = cla3(gg_s[2:0], gp_s[2:0], cin_i);
  assign gcin_s = {gc_s, cin_i};

  for (genvar k = 0; k < 4; k++) begin : g_grp
    logic [2:0] cg_s;
    assign gg_s[k]         = gen4(g_s[4*k +: 4], p_s[4*k +: 4]);
    assign gp_s[k]         = &p_s[4*k +: 4];
    assign cg_s            = cla3(g_s[4*k +: 3], p_s[4*k +: 3], gcin_s[k]);
    assign c_s[4*k +: 4]   = {cg_s, gcin_s[k]};
  end

  assign sum_o  = p_s ^ c_s;
  assign cout_o = gen4(gg_s, gp_s) | ((&gp_s) & cin_i);

endmodule

// File: rtl/multiword_adder.sv
// Sequential WORDS x 16-bit adder/subtractor: one CLA slice per clock, LS slice
// first, slice carry held in a register between cycles.
module multiword_adder
  import multiword_adder_pkg::*;
#(
  parameter int WORDS = 4
) (
  input logic              clk,
  input logic              rst,
  multiword_adder_if.slave bus
);

  localparam int N  = SLICE_W * WORDS;
  localparam int IW = idx_w(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  beff_q, beff_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [IW+SLICE_LG-1:0] base_s;
  logic [SLICE_W-1:0]     cla_a_s;
  logic [SLICE_W-1:0]     cla_b_s;
  logic [SLICE_W-1:0]     cla_sum_s;
  logic                   cla_cout_s;

  assign base_s  = {idx_q, {SLICE_LG{1'b0}}};
  assign cla_a_s = a_q[base_s +: SLICE_W];
  assign cla_b_s = beff_q[base_s +: SLICE_W];

  sixteenbitscarrylookaheadadder u_cla (
    .a_i    (cla_a_s),
    .b_i    (cla_b_s),
    .cin_i  (carry_q),
    .sum_o  (cla_sum_s),
    .cout_o (cla_cout_s)
  );

  // Next-state: operand capture in IDLE, per-slice write-back in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    beff_d  = beff_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          beff_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[base_s +: SLICE_W] = cla_sum_s;
        carry_d                  = cla_cout_s;
        if (idx_q == LAST_IDX) begin
          cout_d  = cla_cout_s;
          ovf_d   = (a_q[N-1] == beff_q[N-1]) & (cla_sum_s[SLICE_W-1] != a_q[N-1]);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      beff_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      beff_q  <= beff_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_multiword_adder.sv
// Directed, table-driven bench for multiword_adder with WORDS=4 (64-bit operands).
module tb_multiword_adder;

  localparam int WORDS = 4;

  typedef struct {
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  initial forever #5 clk = ~clk;

  multiword_adder_if #(.WORDS(WORDS)) bus ();

  multiword_adder #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, drops start after the sampling edge, waits for done.
  task automatic run_op(input logic s, input logic [63:0] a, input logic [63:0] b,
                        input logic c, output int lat);
    bus.sub   = s;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    int first_edge;
    int second_edge;
    int guard;

    vecs[0] = '{1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 64'h1234, 64'h1234, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
                64'h2222_2222_2222_2212, 1'b0, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = 64'h0;
    bus.b     = 64'h0;
    bus.cin   = 1'b0;
    step();
    step();
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_sum", bus.sum, 64'd0);
    check("reset_cout", {63'd0, bus.cout}, 64'd0);
    check("reset_ovf", {63'd0, bus.overflow}, 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd5);
      check($sformatf("v%0d_sum", i), bus.sum, vecs[i].sum);
      check($sformatf("v%0d_cout", i), {63'd0, bus.cout}, {63'd0, vecs[i].cout});
      check($sformatf("v%0d_ovf", i), {63'd0, bus.overflow}, {63'd0, vecs[i].ovf});
      check($sformatf("v%0d_busy_in_done", i), {63'd0, bus.busy}, 64'd1);
      step();
      check($sformatf("v%0d_done_pulse", i), {63'd0, bus.done}, 64'd0);
      check($sformatf("v%0d_idle_busy", i), {63'd0, bus.busy}, 64'd0);
      check($sformatf("v%0d_sum_hold", i), bus.sum, vecs[i].sum);
    end

    // Operands scrambled right after capture must not leak into the result.
    bus.sub   = 1'b0;
    bus.a     = 64'h0000_0000_0000_FFFF;
    bus.b     = 64'h1;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.sub   = 1'b1;
    bus.a     = 64'hDEAD_BEEF_CAFE_F00D;
    bus.b     = 64'h0123_4567_89AB_CDEF;
    bus.cin   = 1'b1;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      step();
      bus.a = bus.a + 64'h1111;
      lat++;
    end
    check("stable_latency", 64'(lat), 64'd5);
    check("stable_sum", bus.sum, 64'h0000_0000_0001_0000);
    check("stable_cout", {63'd0, bus.cout}, 64'd0);
    step();

    // start held high: one op per WORDS+2 cycles, starts during busy dropped.
    bus.sub   = 1'b0;
    bus.a     = 64'h10;
    bus.b     = 64'h20;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    pulses      = 0;
    first_edge  = -1;
    second_edge = -1;
    for (int e = 0; e < 20; e++) begin
      step();
      if (bus.done === 1'b1) begin
        pulses++;
        if (first_edge < 0) first_edge = e;
        else if (second_edge < 0) second_edge = e;
      end
    end
    bus.start = 1'b0;
    check("held_pulses", 64'(pulses), 64'd3);
    check("held_first_done", 64'(first_edge), 64'd4);
    check("held_interval", 64'(second_edge - first_edge), 64'd6);
    check("held_sum", bus.sum, 64'h30);
    guard = 0;
    while (bus.busy === 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    check("held_drain_idle", {63'd0, bus.busy}, 64'd0);

    // Reset while RUN is at slice index 2.
    run_op(vecs[7].sub, vecs[7].a, vecs[7].b, vecs[7].cin, lat);
    check("pre_reset_sum", bus.sum, vecs[7].sum);
    step();
    bus.sub   = vecs[2].sub;
    bus.a     = vecs[2].a;
    bus.b     = vecs[2].b;
    bus.cin   = vecs[2].cin;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_sum", bus.sum, 64'd0);
    check("abort_cout", {63'd0, bus.cout}, 64'd0);
    check("abort_ovf", {63'd0, bus.overflow}, 64'd0);
    pulses = 0;
    for (int e = 0; e < 8; e++) begin
      step();
      if (bus.done === 1'b1) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    run_op(vecs[2].sub, vecs[2].a, vecs[2].b, vecs[2].cin, lat);
    check("post_reset_latency", 64'(lat), 64'd5);
    check("post_reset_sum", bus.sum, vecs[2].sum);
    check("post_reset_ovf", {63'd0, bus.overflow}, 64'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiword_adder.md
# multiword_adder

Sequential wide adder/subtractor that drives the team's 16-bit carry-lookahead adder (`sixteenbitscarrylookaheadadder`) one 16-bit slice per clock. It latches two operands of WORDS×16 bits on a start strobe and feeds slices least-significant first, registering the slice carry-out as the next slice's carry-in. It assembles the full-width result and reports completion with a one-cycle done pulse. It sits upstream of the CLA as its operand/carry sequencer and downstream as the consumer of its sum and cout.

## Interface
- WORDS, 4: number of 16-bit slices; operand width N = 16×WORDS; legal range 2..16.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract (a − b); latched with start.
- a  input  N  operand A; latched with start.
- b  input  N  operand B; latched with start.
- cin  input  1  carry-in for add; ignored when sub=1.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  N  result; held until the next accepted start.
- cout  output  1  carry out of bit N−1; in subtract mode 1 = no borrow.
- overflow  output  1  signed two's-complement overflow of the full-width result.

## Operation
- Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, slice index=0, carry register=0.
- IDLE: start=1 latches a, b, sub. The effective B is b when add and ~b when subtract. The carry register loads cin when add and 1 when subtract. Index is set to 0 and the state goes to RUN. sum, cout and overflow keep their previous values until overwritten.
- RUN: the CLA receives A[16i+15:16i], Beff[16i+15:16i] and the carry register, where i is the index.
  - Each edge writes the CLA sum into sum[16i+15:16i] and loads the carry register from the CLA cout.
  - When i = WORDS−1, the same edge also writes cout from the CLA cout and overflow = (A[N−1] == Beff[N−1]) & (CLA sum[15] != A[N−1]). The state then goes to DONE. Otherwise i increments.
- DONE: done=1 for exactly one cycle, then the state returns to IDLE.
- start while busy is ignored, with no queuing; this includes start in the DONE cycle.
- rst in any state aborts the operation: no done pulse, all outputs return to reset values on that edge.
- Arithmetic is modulo 2^N. The full-width result equals a + b + cin (add) or a + ~b + 1 (subtract). cout and overflow are as defined above.

## Timing
- Edge 0 (start sampled in IDLE): operands latched, busy=1 from the next cycle.
- Edges 1..WORDS: slice 0..WORDS−1 is computed. The carry chain is one register stage per slice, and the CLA path is the only combinational path per cycle.
- Cycle after edge WORDS: done=1, and sum/cout/overflow are final.
- Edge WORDS+1: IDLE, busy=0. A new start is accepted on the next edge, so the issue interval is WORDS+2 cycles.
- Latency from the start edge to done is WORDS+1 cycles (5 for WORDS=4).
- The outputs are registered. The intermediate upper slices of sum hold values from the previous operation during RUN and are not valid before done.

## Structure
- Shared package: state encoding (IDLE, RUN, DONE), the constant SLICE_W=16, and index width $clog2(WORDS).
- One sub-module instance: `sixteenbitscarrylookaheadadder`, driven from mux-selected operand slices and the carry register.
- Slice select and write-back use indexed part-selects on the latched operands and the sum register. No per-slice adder copies.

## Test plan
- Add with WORDS=4: a=0x0000_0000_0000_FFFF, b=0x1, cin=0 -> sum=0x0000_0000_0001_0000, cout=0, overflow=0. done arrives 5 cycles after start.
- Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, overflow=0.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x8000_0000_0000_0000, overflow=1, cout=0.
- Subtract: sub=1, a=5, b=7, cin=1 (cin ignored) -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), overflow=0. Also sub=1, a=b=0x1234 -> sum=0, cout=1.
- Protocol:
  - start held high continuously -> exactly one operation per WORDS+2 cycles, with start ignored while busy.
  - Operands changing during RUN do not affect the result.
- Reset mid-operation: rst asserted at RUN index 2 -> no done pulse, all outputs 0 next cycle. A following start completes normally.
